// File: rtl/ula_pkg.sv
// ula_pkg: shared definitions for the sequential ALU (ula_seq).
// Holds the 3-bit opcode map and the control FSM state encoding.
package ula_pkg;

  localparam logic [2:0] OP_LOAD = 3'b000;
  localparam logic [2:0] OP_ADD  = 3'b001;
  localparam logic [2:0] OP_ADDI = 3'b010;
  localparam logic [2:0] OP_SUB  = 3'b011;
  localparam logic [2:0] OP_SUBI = 3'b100;
  localparam logic [2:0] OP_MUL  = 3'b101;
  localparam logic [2:0] OP_CLR  = 3'b110;
  localparam logic [2:0] OP_DISP = 3'b111;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MUL_RUN = 2'd1,
    DONE    = 2'd2
  } state_t;

endpackage

// File: rtl/ula_seq_if.sv
// ula_seq_if: operand/result handshake bundle between the decoder/register
// file (master) and the sequential ALU (slave).
//   in_valid/in_ready : operation handshake, carries A, B, param (opcode)
//   out_valid/out_ready : result handshake, carries S and overflow
//   busy : multiplier iterating
interface ula_seq_if #(
  parameter int unsigned WIDTH = 16
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [2:0]       param;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] S;
  logic             overflow;
  logic             busy;

  modport master (
    output in_valid, A, B, param, out_ready,
    input  in_ready, out_valid, S, overflow, busy
  );

  modport slave (
    input  in_valid, A, B, param, out_ready,
    output in_ready, out_valid, S, overflow, busy
  );

endinterface

// File: rtl/ula_mul_seq.sv
// ula_mul_seq: iterative shift-add signed multiplier, one partial product per
// cycle, WIDTH cycles per operation (no early exit on zero operands).
//   clk, rst : clock, synchronous active-high reset
//   start    : load a/b and perform the first iteration on this edge
//   a, b     : signed operands
//   done     : one-cycle pulse, product valid from this cycle on
//   product  : full 2*WIDTH-bit signed product, held until next op
module ula_mul_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CNTW = $clog2(WIDTH + 1);

  logic [PW-1:0]    acc_q;
  logic [PW-1:0]    mcand_q;
  logic [WIDTH-1:0] mplier_q;
  logic [CNTW-1:0]  cnt_q;
  logic             neg_q;
  logic             run_q;

  logic [WIDTH-1:0] mag_a_c;
  logic [WIDTH-1:0] mag_b_c;
  logic [PW-1:0]    acc_nxt_c;

  // Magnitudes as unsigned WIDTH bits: -(most negative) wraps to 2^(WIDTH-1),
  // which is exactly the correct unsigned magnitude.
  always_comb begin
    mag_a_c   = a[WIDTH-1] ? WIDTH'(-a) : a;
    mag_b_c   = b[WIDTH-1] ? WIDTH'(-b) : b;
    acc_nxt_c = acc_q + (mplier_q[0] ? mcand_q : '0);
  end

  // Iteration 0 happens on the start edge; iterations 1..WIDTH-1 follow.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      neg_q    <= 1'b0;
      run_q    <= 1'b0;
      done     <= 1'b0;
      product  <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        acc_q    <= mag_b_c[0] ? PW'(mag_a_c) : '0;
        mcand_q  <= PW'(mag_a_c) << 1;
        mplier_q <= mag_b_c >> 1;
        cnt_q    <= CNTW'(1);
        neg_q    <= a[WIDTH-1] ^ b[WIDTH-1];
        run_q    <= 1'b1;
      end else if (run_q) begin
        acc_q    <= acc_nxt_c;
        mcand_q  <= mcand_q << 1;
        mplier_q <= mplier_q >> 1;
        cnt_q    <= cnt_q + CNTW'(1);
        if (cnt_q == CNTW'(WIDTH - 1)) begin
          run_q   <= 1'b0;
          done    <= 1'b1;
          product <= neg_q ? PW'(-acc_nxt_c) : acc_nxt_c;
        end
      end
    end
  end

endmodule

// File: rtl/ula_seq.sv
// ula_seq: handshaked sequential ALU. Registers every result, reports signed
// overflow, multiplies with the iterative ula_mul_seq unit.
//   clk, rst : clock, synchronous active-high reset
//   bus      : ula_seq_if slave (in_valid/in_ready/A/B/param,
//              out_valid/out_ready/S/overflow, busy)
// Optional build macro ULA_SAT_EN: saturate S on overflow instead of wrapping.
module ula_seq
  import ula_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst,
  ula_seq_if.slave   bus
);

  localparam int unsigned      PW   = 2 * WIDTH;
  localparam logic [WIDTH-1:0] SMAX = {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  state_t           state_q, state_n;
  logic [WIDTH-1:0] a_q, b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] s_q, s_n;
  logic             ovf_q, ovf_n;
  logic             ov_q, ov_n;
  logic             ir_q, ir_n;
  logic             busy_q, busy_n;
  logic             latch_c;
  logic             mul_start_c;

  logic             mul_done;
  logic [PW-1:0]    mul_prod;

  logic [WIDTH-1:0] sum_c, dif_c;
  logic [WIDTH-1:0] res_wrap_c;
  logic [WIDTH-1:0] res_c;
  logic             res_ovf_c;

  ula_mul_seq #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (mul_start_c),
    .a       (bus.A),
    .b       (bus.B),
    .done    (mul_done),
    .product (mul_prod)
  );

  // Result and overflow from the latched operation.
  always_comb begin
    sum_c      = a_q + b_q;
    dif_c      = a_q - b_q;
    res_wrap_c = '0;
    res_ovf_c  = 1'b0;
    case (op_q)
      OP_LOAD: res_wrap_c = b_q;
      OP_ADD, OP_ADDI: begin
        res_wrap_c = sum_c;
        res_ovf_c  = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_SUB, OP_SUBI: begin
        res_wrap_c = dif_c;
        res_ovf_c  = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (dif_c[WIDTH-1] != a_q[WIDTH-1]);
      end
      OP_MUL: begin
        res_wrap_c = mul_prod[WIDTH-1:0];
        // Fits in WIDTH bits only if the top WIDTH+1 bits are all equal.
        res_ovf_c  = (mul_prod[PW-1:WIDTH-1] != '0) && (mul_prod[PW-1:WIDTH-1] != '1);
      end
      OP_CLR:  res_wrap_c = '0;
      OP_DISP: res_wrap_c = a_q;
      default: res_wrap_c = '0;
    endcase
  end

`ifdef ULA_SAT_EN
  logic res_neg_c;

  // On add/sub overflow the true result has A's sign; for MUL the full product's.
  always_comb begin
    res_neg_c = (op_q == OP_MUL) ? mul_prod[PW-1] : a_q[WIDTH-1];
    res_c     = res_ovf_c ? (res_neg_c ? SMIN : SMAX) : res_wrap_c;
  end
`else
  always_comb begin
    res_c = res_wrap_c;
  end
`endif

  // Control FSM: DONE spends its first cycle writing back, then waits for out_ready.
  always_comb begin
    state_n     = state_q;
    s_n         = s_q;
    ovf_n       = ovf_q;
    ov_n        = ov_q;
    latch_c     = 1'b0;
    mul_start_c = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.in_valid && ir_q) begin
          latch_c = 1'b1;
          if (bus.param == OP_MUL) begin
            mul_start_c = 1'b1;
            state_n     = MUL_RUN;
          end else begin
            state_n = DONE;
          end
        end
      end
      MUL_RUN: begin
        if (mul_done) state_n = DONE;
      end
      DONE: begin
        if (!ov_q) begin
          s_n   = res_c;
          ovf_n = res_ovf_c;
          ov_n  = 1'b1;
        end else if (bus.out_ready) begin
          ov_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    ir_n   = (state_n == IDLE);
    busy_n = (state_n == MUL_RUN);
  end

  // State and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= '0;
      ovf_q   <= 1'b0;
      ov_q    <= 1'b0;
      ir_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      s_q     <= s_n;
      ovf_q   <= ovf_n;
      ov_q    <= ov_n;
      ir_q    <= ir_n;
      busy_q  <= busy_n;
    end
  end

  // Operand capture on accept; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (latch_c) begin
      a_q  <= bus.A;
      b_q  <= bus.B;
      op_q <= bus.param;
    end
  end

  assign bus.in_ready  = ir_q;
  assign bus.out_valid = ov_q;
  assign bus.S         = s_q;
  assign bus.overflow  = ovf_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_ula_seq.sv
// tb_ula_seq: randomized self-checking bench for ula_seq against an
// integer-arithmetic reference model (honours ULA_SAT_EN).
module tb_ula_seq;
  import ula_pkg::*;

  localparam int unsigned W = 16;
  localparam longint MAXV = (longint'(1) << (W - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (W - 1));

  logic clk;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  ula_seq_if #(.WIDTH(W)) bus ();

  ula_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer result, range check, then wrap or clamp.
  function automatic void model(input logic [2:0] op, input logic [W-1:0] a,
                                input logic [W-1:0] b, output logic [W-1:0] s,
                                output logic ov);
    longint sa;
    longint sb;
    longint r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      3'd0:       r = sb;
      3'd1, 3'd2: r = sa + sb;
      3'd3, 3'd4: r = sa - sb;
      3'd5:       r = sa * sb;
      3'd6:       r = 0;
      default:    r = sa;
    endcase
    ov = (r > MAXV) || (r < MINV);
`ifdef ULA_SAT_EN
    if (r > MAXV) r = MAXV;
    else if (r < MINV) r = MINV;
`endif
    s = W'(r);
  endfunction

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input bit rdy_early);
    logic [W-1:0] es;
    logic         eo;
    int           lat;
    int           bsy;
    int           n;
    model(op, a, b, es, eo);
    bus.in_valid  = 1'b1;
    bus.A         = a;
    bus.B         = b;
    bus.param     = op;
    bus.out_ready = rdy_early;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    chk("accept_wait", 64'(n < 50), 64'(1));
    @(posedge clk); #1;
    chk("in_ready_after_accept", 64'(bus.in_ready), 64'(0));
    bsy = int'(bus.busy);
    lat = 0;
    // Garbage with in_valid still high: must be neither latched nor accepted.
    bus.A     = W'($urandom);
    bus.B     = W'($urandom);
    bus.param = 3'($urandom);
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
      bsy += int'(bus.busy);
    end
    chk("latency", 64'(lat), 64'((op == OP_MUL) ? W + 1 : 1));
    chk("busy_cycles", 64'(bsy), 64'((op == OP_MUL) ? W : 0));
    chk("S", 64'(bus.S), 64'(es));
    chk("overflow", 64'(bus.overflow), 64'(eo));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_out_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_S", 64'(bus.S), 64'(es));
      chk("hold_in_ready", 64'(bus.in_ready), 64'(0));
    end
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    chk("in_ready_after_release", 64'(bus.in_ready), 64'(1));
    chk("out_valid_after_release", 64'(bus.out_valid), 64'(0));
  endtask

  function automatic logic [W-1:0] pick_operand();
    logic [W-1:0] corner [5];
    corner[0] = 16'h8000;
    corner[1] = 16'h7FFF;
    corner[2] = 16'hFFFF;
    corner[3] = 16'h0000;
    corner[4] = 16'h0001;
    if ($urandom_range(0, 3) == 0) return corner[$urandom_range(0, 4)];
    return W'($urandom);
  endfunction

  initial begin
    int  n;
    bit  seen;
    bit  early;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.A         = '0;
    bus.B         = '0;
    bus.param     = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_S", 64'(bus.S), 64'(0));
    chk("rst_overflow", 64'(bus.overflow), 64'(0));
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_busy", 64'(bus.busy), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;
    chk("in_ready_after_rst", 64'(bus.in_ready), 64'(1));

    // Directed corners.
    run_op(OP_ADD,  16'h7FFF, 16'h0001, 0, 1'b0);
    run_op(OP_SUBI, 16'h0005, 16'h0009, 0, 1'b0);
    run_op(OP_SUB,  16'h8000, 16'h0001, 0, 1'b0);
    run_op(OP_MUL,  16'hFFFD, 16'h0007, 0, 1'b0);
    run_op(OP_MUL,  16'd300,  16'd300,  0, 1'b0);
    run_op(OP_MUL,  16'h8000, 16'hFFFF, 0, 1'b0);
    run_op(OP_MUL,  16'h0000, 16'hFFFB, 0, 1'b1);
    run_op(OP_LOAD, 16'hA5A5, 16'h1234, 5, 1'b0);
    run_op(OP_CLR,  16'h5555, 16'h3333, 0, 1'b0);
    run_op(OP_DISP, 16'hBEEF, 16'h0101, 0, 1'b1);

    // Reset during cycle 8 of a multiply aborts it.
    bus.in_valid = 1'b1;
    bus.A        = 16'h0123;
    bus.B        = 16'h0045;
    bus.param    = OP_MUL;
    n = 0;
    while (!bus.in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    chk("mul_busy_before_rst", 64'(bus.busy), 64'(1));
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_out_valid", 64'(bus.out_valid), 64'(0));
    chk("abort_S", 64'(bus.S), 64'(0));
    chk("abort_overflow", 64'(bus.overflow), 64'(0));
    chk("abort_busy", 64'(bus.busy), 64'(0));
    @(posedge clk); #1;
    chk("abort_in_ready", 64'(bus.in_ready), 64'(1));
    seen = 1'b0;
    bus.out_ready = 1'b1;
    repeat (25) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen = 1'b1;
    end
    bus.out_ready = 1'b0;
    chk("abort_no_out_valid", 64'(seen), 64'(0));
    run_op(OP_ADD, 16'd2, 16'd2, 0, 1'b0);

    // Randomized operations.
    for (int i = 0; i < 60; i++) begin
      early = 1'($urandom_range(0, 1));
      run_op(3'($urandom_range(0, 7)), pick_operand(), pick_operand(),
             early ? 0 : int'($urandom_range(0, 3)), early);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ula_seq.md
Name: ula_seq

Overview:
Parametrised, handshaked successor to the combinational 16-bit ALU.
- Same 3-bit opcode map: LOAD, ADD, ADDI, SUB, SUBI, MUL, CLEAR, DISPLAY.
- Registers every result and reports signed overflow.
- Replaces the combinational multiplier with an iterative shift-add unit of WIDTH cycles.
- Sits between the instruction decoder/register file and the writeback/display path; valid/ready on both sides.

Parameters:
WIDTH, 16, operand and result width in bits, signed two's complement, minimum 4.
CNTW, $clog2(WIDTH+1), width of the multiplier iteration counter; derived, not overridden.

Ports:
clk  in  1  system clock, rising edge.
rst  in  1  synchronous, active-high reset.
in_valid  in  1  operands and opcode present.
in_ready  out  1  block can accept an operation.
A  in  WIDTH  signed operand A.
B  in  WIDTH  signed operand B (register value or immediate).
param  in  3  opcode.
out_valid  out  1  S/overflow valid.
out_ready  in  1  consumer takes result.
S  out  WIDTH  signed result, registered.
overflow  out  1  signed overflow of the completed op.
busy  out  1  high while in MUL_RUN.

Behaviour:
- Clock and reset: one clock; rst is synchronous, active-high.
- Reset values: state IDLE, S=0, overflow=0, out_valid=0, busy=0. in_ready is 0 while rst is high and 1 on the first cycle after.
- States and transitions:
  - IDLE: in_ready=1. Accept when in_valid & in_ready; A, B and param are latched. MUL goes to MUL_RUN; every other opcode writes S/overflow and goes to DONE.
  - MUL_RUN: in_ready=0, busy=1. Runs exactly WIDTH iterations, one per cycle. After the last iteration, S/overflow are written and the state goes to DONE.
  - DONE: out_valid=1, in_ready=0. S and overflow are held stable until out_ready=1, then IDLE on the next edge.
- Latency, counted in edges after the accept edge:
  - Non-MUL: out_valid rises 1 edge later.
  - MUL: out_valid rises WIDTH+1 edges later.
- Throughput: at most one op per 2 cycles; there is no accept in DONE, even when out_ready is high.
- Opcode results:
  - 000 LOAD: S=B.
  - 001 ADD / 010 ADDI: S=A+B.
  - 011 SUB / 100 SUBI: S=A-B.
  - 101 MUL: S = low WIDTH bits of signed A*B.
  - 110 CLEAR: S=0.
  - 111 DISPLAY: S=A.
- overflow is 0 for LOAD, CLEAR and DISPLAY. It is 1 when:
  - ADD/ADDI: operand signs are equal and the result sign differs.
  - SUB/SUBI: operand signs differ and the result sign differs from A.
  - MUL: the full 2*WIDTH signed product lies outside [-2^(WIDTH-1), 2^(WIDTH-1)-1].
- Multiplier arithmetic:
  - Latch magnitudes |A| and |B| as unsigned WIDTH bits; |most-negative| = 2^(WIDTH-1) must be handled.
  - Product sign = A[msb]^B[msb].
  - 2*WIDTH-bit unsigned accumulator; each iteration conditionally adds the shifted multiplicand and advances the counter.
  - Negate the product at the end if the sign is set.
  - A zero operand still takes WIDTH cycles (no early exit).
- Boundary conditions:
  - Inputs that change after the accept edge are ignored.
  - in_valid while in MUL_RUN/DONE is not accepted; the upstream holds it.
  - rst asserted mid-MUL or in DONE aborts the op: IDLE, outputs cleared next edge, no out_valid pulse.
  - out_ready while out_valid=0 has no effect.

Optional Feature:
ULA_SAT_EN
- Defined: when overflow=1, S saturates to 2^(WIDTH-1)-1 for positive true results and -2^(WIDTH-1) for negative; overflow is still reported.
- Undefined: S wraps to the low WIDTH bits.
- Latency is identical either way.

Decomposition:
- Package ula_pkg:
  - opcode localparams OP_LOAD=3'b000, OP_ADD, OP_ADDI, OP_SUB, OP_SUBI, OP_MUL, OP_CLR, OP_DISP=3'b111;
  - state encoding IDLE/MUL_RUN/DONE.
- Sub-module ula_mul_seq, parametrised by WIDTH:
  - inputs start, a, b;
  - outputs done (one-cycle pulse) and 2*WIDTH-bit signed product;
  - synchronous rst.
- The top keeps the FSM, add/sub, overflow and saturation logic.

Test Plan:
- ADD A=0x7FFF, B=0x0001 -> S=0x8000, overflow=1, out_valid 1 edge after accept. With ULA_SAT_EN: S=0x7FFF.
- SUBI A=0x0005, B=0x0009 -> S=0xFFFC (-4), overflow=0. Then SUB A=0x8000, B=0x0001 -> overflow=1 (sat: S=0x8000).
- MUL A=-3 (0xFFFD), B=7 -> S=0xFFEB (-21), overflow=0, out_valid exactly 17 edges after accept, busy high for 16 cycles. MUL A=300, B=300 -> overflow=1, S=0x5F90 (sat: 0x7FFF).
- MUL A=0x8000, B=0xFFFF -> product +32768: overflow=1, S=0x8000 (sat: 0x7FFF).
- LOAD B=0x1234 then hold out_ready=0 for 5 cycles -> S=0x1234 and out_valid stable, in_ready=0. Release -> IDLE, in_ready=1 next cycle. CLEAR -> S=0. DISPLAY A=0xBEEF -> S=0xBEEF.
- Assert rst for one cycle during cycle 8 of a MUL -> no out_valid, S=0, in_ready=1 after release. A new ADD 2+2 then returns S=4.
